// File: rtl/sad_search_ctrl_if.sv
// Handshake and datapath-control bundle for the SAD search controller.
// The controller takes the slave side. The master side starts and aborts a
// search and returns the accumulated SAD.
interface sad_search_ctrl_if #(
  parameter int ROWS     = 8,
  parameter int NUM_CAND = 16
);
  localparam int CW = $clog2(NUM_CAND);
  localparam int RW = $clog2(ROWS);

  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          row_valid;
  logic [RW-1:0] row_addr;
  logic [CW-1:0] cand_idx;
  logic          dp_clr;
  logic [15:0]   dp_sum;
  logic [15:0]   best_sad;
  logic [CW-1:0] best_idx;

  modport master (
    output start, abort, dp_sum,
    input  busy, done, row_valid, row_addr, cand_idx, dp_clr, best_sad, best_idx
  );

  modport slave (
    input  start, abort, dp_sum,
    output busy, done, row_valid, row_addr, cand_idx, dp_clr, best_sad, best_idx
  );
endinterface

// File: rtl/sad_search_ctrl.sv
// Sequencing controller for the 8-pixel-wide SAD accumulator datapath.
// For every candidate the controller clears the accumulator, feeds the rows,
// and waits for the pipeline to drain. It then compares the SAD against the
// running minimum. The best candidate is reported with a single-cycle done
// pulse. All outputs are registered.
module sad_search_ctrl #(
  parameter int ROWS     = 8,
  parameter int NUM_CAND = 16,
  parameter int CLR_CYC  = 2,
  parameter int DP_LAT   = 3,
  parameter int CW       = $clog2(NUM_CAND),
  parameter int RW       = $clog2(ROWS)
) (
  input logic               clk,
  input logic               reset,
  sad_search_ctrl_if.slave  bus
);

  localparam int CNT_MAX = (ROWS > CLR_CYC) ? ((ROWS > DP_LAT) ? ROWS : DP_LAT)
                                            : ((CLR_CYC > DP_LAT) ? CLR_CYC : DP_LAT);
  localparam int CNTW = $clog2(CNT_MAX + 1);

  localparam logic [CNTW-1:0] CLR_LOAD  = CNTW'(CLR_CYC - 1);
  localparam logic [CNTW-1:0] FEED_LOAD = CNTW'(ROWS - 1);
  localparam logic [CNTW-1:0] LAT_LOAD  = CNTW'(DP_LAT - 1);
  localparam logic [CW-1:0]   LAST_CAND = CW'(NUM_CAND - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_CMP,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [CW-1:0]   cand_q;
  logic [RW-1:0]   row_q;
  logic            row_valid_q;
  logic            dp_clr_q;
  logic            busy_q;
  logic            done_q;
  logic [15:0]     min_sad_q;
  logic [CW-1:0]   min_idx_q;
  logic [15:0]     best_sad_q;
  logic [CW-1:0]   best_idx_q;

  logic            take;
  logic [15:0]     nxt_min_sad;
  logic [CW-1:0]   nxt_min_idx;

  // Running-minimum update. The first candidate always loads. A strict
  // compare keeps the lower index on a tie.
  always_comb begin
    take        = (cand_q == '0) || (bus.dp_sum < min_sad_q);
    nxt_min_sad = take ? bus.dp_sum : min_sad_q;
    nxt_min_idx = take ? cand_q : min_idx_q;
  end

  // Search FSM. Every output is produced directly as a register here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      row_q       <= '0;
      row_valid_q <= 1'b0;
      dp_clr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      min_sad_q   <= '0;
      min_idx_q   <= '0;
      best_sad_q  <= '0;
      best_idx_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort && state_q != S_IDLE) begin
        // Abort flushes the datapath for one cycle and drops the search.
        state_q     <= S_IDLE;
        cnt_q       <= '0;
        cand_q      <= '0;
        row_q       <= '0;
        row_valid_q <= 1'b0;
        dp_clr_q    <= 1'b1;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            dp_clr_q    <= 1'b0;
            row_valid_q <= 1'b0;
            if (bus.start && !bus.abort) begin
              state_q  <= S_CLEAR;
              busy_q   <= 1'b1;
              dp_clr_q <= 1'b1;
              cand_q   <= '0;
              cnt_q    <= CLR_LOAD;
            end
          end
          S_CLEAR: begin
            if (cnt_q == '0) begin
              state_q     <= S_FEED;
              dp_clr_q    <= 1'b0;
              row_valid_q <= 1'b1;
              row_q       <= '0;
              cnt_q       <= FEED_LOAD;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_FEED: begin
            if (cnt_q == '0) begin
              state_q     <= S_DRAIN;
              row_valid_q <= 1'b0;
              row_q       <= '0;
              cnt_q       <= LAT_LOAD;
            end else begin
              row_q <= row_q + 1'b1;
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_DRAIN: begin
            if (cnt_q == '0) begin
              state_q <= S_CMP;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_CMP: begin
            min_sad_q <= nxt_min_sad;
            min_idx_q <= nxt_min_idx;
            if (cand_q == LAST_CAND) begin
              // Publish the post-compare minimum so the last candidate counts.
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              best_sad_q <= nxt_min_sad;
              best_idx_q <= nxt_min_idx;
            end else begin
              state_q  <= S_CLEAR;
              cand_q   <= cand_q + 1'b1;
              dp_clr_q <= 1'b1;
              cnt_q    <= CLR_LOAD;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cand_q  <= '0;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.row_valid = row_valid_q;
  assign bus.row_addr  = row_q;
  assign bus.cand_idx  = cand_q;
  assign bus.dp_clr    = dp_clr_q;
  assign bus.best_sad  = best_sad_q;
  assign bus.best_idx  = best_idx_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl. A behavioural datapath turns per-candidate
// target SADs into row contributions, which arrive DP_LAT cycles after
// issue. The expected schedule and the best candidate are derived from
// cycle arithmetic and a plain argmin over the targets.
module tb_sad_search_ctrl;
  localparam int ROWS     = 8;
  localparam int NUM_CAND = 16;
  localparam int CLR      = 2;
  localparam int LAT      = 3;
  localparam int CW       = $clog2(NUM_CAND);
  localparam int PER      = CLR + ROWS + LAT + 1;
  localparam int TOT      = NUM_CAND * PER;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   tgt [NUM_CAND];
  logic [15:0]   exp_sad = '0;
  logic [CW-1:0] exp_idx = '0;

  sad_search_ctrl_if #(.ROWS(ROWS), .NUM_CAND(NUM_CAND)) bus ();

  sad_search_ctrl #(
    .ROWS(ROWS), .NUM_CAND(NUM_CAND), .CLR_CYC(CLR), .DP_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural datapath. A row issued in cycle t becomes visible on dp_sum in cycle t+LAT.
  function automatic logic [15:0] contrib(input int cand, input int row);
    int t;
    t = tgt[cand];
    return 16'(t / ROWS + ((row == 0) ? t % ROWS : 0));
  endfunction

  logic s1v, s2v;
  int s1c, s2c, s1r, s2r;
  logic [15:0] acc;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1v <= 1'b0; s2v <= 1'b0; s1c <= 0; s2c <= 0; s1r <= 0; s2r <= 0; acc <= '0;
    end else begin
      s1v <= bus.row_valid; s1c <= int'(bus.cand_idx); s1r <= int'(bus.row_addr);
      s2v <= s1v; s2c <= s1c; s2r <= s1r;
      if (bus.dp_clr) acc <= '0;
      else if (s2v) acc <= acc + contrib(s2c, s2r);
    end
  end
  assign bus.dp_sum = acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_row_valid"}, 32'(bus.row_valid), 0);
    check({tag, "_row_addr"}, 32'(bus.row_addr), 0);
    check({tag, "_cand_idx"}, 32'(bus.cand_idx), 0);
    check({tag, "_dp_clr"}, 32'(bus.dp_clr), 0);
    check({tag, "_best_sad"}, 32'(bus.best_sad), 0);
    check({tag, "_best_idx"}, 32'(bus.best_idx), 0);
  endtask

  // One search from IDLE. Optional abort, reset or stray start at a given cycle (-1 = none).
  task automatic run_search(input int abort_cyc, input int reset_cyc, input int restart_cyc);
    logic [15:0]   es;
    logic [CW-1:0] ei;
    int nbusy, ndone, o;
    es = '0; ei = '0; nbusy = 0; ndone = 0;
    for (int i = 0; i < NUM_CAND; i++)
      if (i == 0 || tgt[i] < int'(es)) begin es = 16'(tgt[i]); ei = CW'(i); end
    bus.start = 1'b1;
    for (int c = 0; c < TOT + 2; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (c == reset_cyc) begin
        reset = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(negedge clk);
        check_all_zero("rst_next");
        reset = 1'b1;
        exp_sad = '0;
        exp_idx = '0;
        return;
      end
      if (abort_cyc >= 0 && c == abort_cyc + 1) begin
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_dp_clr", 32'(bus.dp_clr), 1);
        check("abort_done", 32'(bus.done), 0);
        check("abort_row_valid", 32'(bus.row_valid), 0);
        check("abort_best_sad", 32'(bus.best_sad), 32'(exp_sad));
        check("abort_best_idx", 32'(bus.best_idx), 32'(exp_idx));
        @(negedge clk);
        check("abort_after_dp_clr", 32'(bus.dp_clr), 0);
        check("abort_after_busy", 32'(bus.busy), 0);
        check("abort_after_done", 32'(bus.done), 0);
        return;
      end
      nbusy += int'(bus.busy);
      ndone += int'(bus.done);
      if (c < TOT) begin
        o = c % PER;
        check("busy", 32'(bus.busy), 1);
        check("done_early", 32'(bus.done), 0);
        check("cand_idx", 32'(bus.cand_idx), 32'(c / PER));
        check("dp_clr", 32'(bus.dp_clr), 32'(o < CLR));
        check("row_valid", 32'(bus.row_valid), 32'(o >= CLR && o < CLR + ROWS));
        check("row_addr", 32'(bus.row_addr), (o >= CLR && o < CLR + ROWS) ? 32'(o - CLR) : 0);
        check("best_sad_hold", 32'(bus.best_sad), 32'(exp_sad));
        check("best_idx_hold", 32'(bus.best_idx), 32'(exp_idx));
      end else if (c == TOT) begin
        check("done_pulse", 32'(bus.done), 1);
        check("done_busy", 32'(bus.busy), 1);
        check("done_dp_clr", 32'(bus.dp_clr), 0);
        check("done_row_valid", 32'(bus.row_valid), 0);
        check("best_sad", 32'(bus.best_sad), 32'(es));
        check("best_idx", 32'(bus.best_idx), 32'(ei));
        exp_sad = es;
        exp_idx = ei;
      end else begin
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_done", 32'(bus.done), 0);
        check("idle_cand_idx", 32'(bus.cand_idx), 0);
        check("busy_cycles", 32'(nbusy), 32'(TOT + 1));
        check("done_count", 32'(ndone), 1);
        check("best_sad_kept", 32'(bus.best_sad), 32'(exp_sad));
      end
      bus.start = (c == restart_cyc);
      bus.abort = (c == abort_cyc);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) tgt[i] = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // start and abort together in IDLE, then abort alone in IDLE
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("idle_start_abort_busy", 32'(bus.busy), 0);
    check("idle_start_abort_dp_clr", 32'(bus.dp_clr), 0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("idle_abort_dp_clr", 32'(bus.dp_clr), 0);
    check("idle_abort_busy", 32'(bus.busy), 0);

    // basic search
    for (int i = 0; i < NUM_CAND; i++) tgt[i] = 1000 + 10 * i;
    tgt[9] = 37;
    run_search(-1, -1, -1);

    // reset mid-FEED of candidate 5
    run_search(-1, 5 * PER + CLR + 4, -1);

    // tie between idx 3 and idx 11
    for (int i = 0; i < NUM_CAND; i++) tgt[i] = 200;
    tgt[3] = 50; tgt[11] = 50;
    run_search(-1, -1, -1);

    // abort in DRAIN of idx 6, then a clean restart
    for (int i = 0; i < NUM_CAND; i++) tgt[i] = int'($urandom_range(0, 16320));
    run_search(6 * PER + CLR + ROWS + 1, -1, -1);
    run_search(-1, -1, -1);

    // start re-asserted while busy is ignored
    for (int i = 0; i < NUM_CAND; i++) tgt[i] = int'($urandom_range(0, 16320));
    run_search(-1, -1, 50);

    // all candidates saturated: first candidate must load
    for (int i = 0; i < NUM_CAND; i++) tgt[i] = 65535;
    run_search(-1, -1, -1);

    // random searches, some with many ties
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NUM_CAND; i++)
        tgt[i] = (r % 2 == 0) ? int'($urandom_range(0, 16320)) : int'($urandom_range(1, 4)) * 100;
      run_search(-1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
